// File: rtl/demux_alternante.sv
// demux_alternante: 1-to-2 demultiplexer that deals accepted words onto two
// lanes in strict alternation (lane 0, lane 1, lane 0, ...). Each lane has a
// single registered holding stage with its own valid/ready handshake, so the
// two consumers can stall independently. Upstream ready follows the lane that
// is due next, with pass-through ready so a draining lane can reload in the
// same cycle.
module demux_alternante #(
  parameter int BUS_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] data_in,
  input  logic                 valid_in,
  output logic                 ready_in,
  output logic [BUS_WIDTH-1:0] data_out_0,
  output logic                 valid_out_0,
  input  logic                 ready_0,
  output logic [BUS_WIDTH-1:0] data_out_1,
  output logic                 valid_out_1,
  input  logic                 ready_1,
  output logic                 selector
);

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_t;

  lane_state_t          lane0_state_q, lane0_state_d;
  lane_state_t          lane1_state_q, lane1_state_d;
  logic [BUS_WIDTH-1:0] data0_q, data0_d;
  logic [BUS_WIDTH-1:0] data1_q, data1_d;
  logic                 sel_q, sel_d;

  logic                 accept_s;
  logic                 load0_s;
  logic                 load1_s;

  // Upstream handshake: only the lane due next decides whether a word can
  // enter; a stalled due lane blocks input even if the other lane is empty.
  always_comb begin
    ready_in = 1'b0;
    if (reset) begin
      ready_in = 1'b0;
    end else if (sel_q == 1'b0) begin
      ready_in = (lane0_state_q == LANE_EMPTY) || ready_0;
    end else begin
      ready_in = (lane1_state_q == LANE_EMPTY) || ready_1;
    end
  end

  // Accept decode: an accepted word goes to the lane named by the selector.
  always_comb begin
    accept_s = valid_in && ready_in;
    load0_s  = accept_s && (sel_q == 1'b0);
    load1_s  = accept_s && (sel_q == 1'b1);
    if (accept_s) begin
      sel_d = ~sel_q;
    end else begin
      sel_d = sel_q;
    end
  end

  // Lane 0 next state: load wins over drain; data changes only on load.
  always_comb begin
    lane0_state_d = lane0_state_q;
    data0_d       = data0_q;
    case (lane0_state_q)
      LANE_EMPTY: begin
        if (load0_s) begin
          lane0_state_d = LANE_FULL;
          data0_d       = data_in;
        end else begin
          lane0_state_d = LANE_EMPTY;
        end
      end
      LANE_FULL: begin
        if (load0_s) begin
          lane0_state_d = LANE_FULL;
          data0_d       = data_in;
        end else if (ready_0) begin
          lane0_state_d = LANE_EMPTY;
        end else begin
          lane0_state_d = LANE_FULL;
        end
      end
      default: begin
        lane0_state_d = LANE_EMPTY;
      end
    endcase
  end

  // Lane 1 next state: same holding-stage behaviour as lane 0.
  always_comb begin
    lane1_state_d = lane1_state_q;
    data1_d       = data1_q;
    case (lane1_state_q)
      LANE_EMPTY: begin
        if (load1_s) begin
          lane1_state_d = LANE_FULL;
          data1_d       = data_in;
        end else begin
          lane1_state_d = LANE_EMPTY;
        end
      end
      LANE_FULL: begin
        if (load1_s) begin
          lane1_state_d = LANE_FULL;
          data1_d       = data_in;
        end else if (ready_1) begin
          lane1_state_d = LANE_EMPTY;
        end else begin
          lane1_state_d = LANE_FULL;
        end
      end
      default: begin
        lane1_state_d = LANE_EMPTY;
      end
    endcase
  end

  // State registers; reset discards any held words and restarts at lane 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane0_state_q <= LANE_EMPTY;
      lane1_state_q <= LANE_EMPTY;
      data0_q       <= {BUS_WIDTH{1'b0}};
      data1_q       <= {BUS_WIDTH{1'b0}};
      sel_q         <= 1'b0;
    end else begin
      lane0_state_q <= lane0_state_d;
      lane1_state_q <= lane1_state_d;
      data0_q       <= data0_d;
      data1_q       <= data1_d;
      sel_q         <= sel_d;
    end
  end

  // Outputs come straight from the registers.
  always_comb begin
    data_out_0  = data0_q;
    data_out_1  = data1_q;
    valid_out_0 = (lane0_state_q == LANE_FULL);
    valid_out_1 = (lane1_state_q == LANE_FULL);
    selector    = sel_q;
  end

endmodule
